// File: rtl/loop_recorder_pkg.sv
// Shared types for the loop recorder: FSM state encoding and the per-tick output operation.
package loop_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECORD  = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVERDUB = 2'd3
  } state_e;

  // What the output stage does with the sample launched on a tick.
  typedef enum logic [1:0] {
    OP_ZERO = 2'd0,
    OP_PASS = 2'd1,
    OP_MIX  = 2'd2
  } op_e;

endpackage

// File: rtl/loop_recorder_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a registered read.
module loop_recorder_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/loop_recorder.sv
// Sample loop recorder/looper: records sig_in into RAM, replays it with wrap, overdubs with saturation.
// Per tick at T: read mem[ptr] and latch sig_in; T+1: mix and write back; T+2: sig_out/out_valid.
module loop_recorder
  import loop_recorder_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 12,
  parameter int MONITOR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sig_in,
  input  logic              rec,
  input  logic              play,
  input  logic              overdub,
  input  logic              clear,
  output logic [DATA_W-1:0] sig_out,
  output logic              out_valid,
  output logic [ADDR_W:0]   loop_len,
  output logic              loop_valid,
  output logic [1:0]        state
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              valid_q, valid_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_we_q, s1_we_d;
  op_e               s1_op_q, s1_op_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0] s1_in_q, s1_in_d;
  logic [DATA_W-1:0] sig_out_q, sig_out_d;
  logic              out_valid_q, out_valid_d;

  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] mix;
  logic              ptr_wrap;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      return sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
    return sum[DATA_W-1:0];
  endfunction

  assign mix      = sat_add(ram_rdata, s1_in_q);
  assign ptr_wrap = ({1'b0, ptr_q} == (len_q - LEN_ONE));

  // clear on the write cycle kills the overdub write of the tick in flight.
  assign ram_we    = s1_valid_q && s1_we_q && !clear;
  assign ram_wdata = (s1_op_q == OP_PASS) ? s1_in_q : mix;

  loop_recorder_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(s1_addr_q),
    .wdata(ram_wdata),
    .raddr(ptr_q),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    valid_d     = valid_q;
    s1_valid_d  = 1'b0;
    s1_we_d     = 1'b0;
    s1_op_d     = s1_op_q;
    s1_addr_d   = s1_addr_q;
    s1_in_d     = s1_in_q;
    sig_out_d   = sig_out_q;
    out_valid_d = 1'b0;

    if (s1_valid_q) begin
      out_valid_d = 1'b1;
      case (s1_op_q)
        OP_ZERO: sig_out_d = '0;
        OP_PASS: sig_out_d = s1_in_q;
        default: sig_out_d = (MONITOR != 0) ? mix : ram_rdata;
      endcase
    end

    if (sample_tick) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = ptr_q;
      s1_in_d    = sig_in;
      unique case (state_q)
        ST_IDLE: begin
          s1_op_d = OP_ZERO;
          if (rec) begin
            state_d = ST_RECORD;
            ptr_d   = '0;
            len_d   = '0;
            valid_d = 1'b0;
          end else if (play && valid_q) begin
            state_d = ST_PLAY;
            ptr_d   = '0;
          end
        end
        ST_RECORD: begin
          s1_op_d = OP_PASS;
          if (rec) begin
            s1_we_d = 1'b1;
            if (ptr_q == PTR_MAX) begin
              len_d   = LEN_FULL;
              valid_d = 1'b1;
              ptr_d   = '0;
              state_d = ST_PLAY;
            end else begin
              ptr_d = ptr_q + PTR_ONE;
            end
          end else if (ptr_q != '0) begin
            len_d   = {1'b0, ptr_q};
            valid_d = 1'b1;
            ptr_d   = '0;
            state_d = ST_PLAY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PLAY, ST_OVERDUB: begin
          s1_op_d = OP_MIX;
          if (rec) begin
            state_d = ST_RECORD;
            ptr_d   = '0;
            len_d   = '0;
            valid_d = 1'b0;
          end else if (!play) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
          end else begin
            // The tick that enters overdub already writes; the tick that leaves it does not.
            state_d = overdub ? ST_OVERDUB : ST_PLAY;
            s1_we_d = overdub;
            ptr_d   = ptr_wrap ? '0 : ptr_q + PTR_ONE;
          end
        end
      endcase
    end

    if (clear) begin
      state_d     = ST_IDLE;
      ptr_d       = '0;
      len_d       = '0;
      valid_d     = 1'b0;
      sig_out_d   = '0;
      out_valid_d = 1'b0;
      s1_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      valid_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_we_q     <= 1'b0;
      s1_op_q     <= OP_ZERO;
      s1_addr_q   <= '0;
      s1_in_q     <= '0;
      sig_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      s1_valid_q  <= s1_valid_d;
      s1_we_q     <= s1_we_d;
      s1_op_q     <= s1_op_d;
      s1_addr_q   <= s1_addr_d;
      s1_in_q     <= s1_in_d;
      sig_out_q   <= sig_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sig_out    = sig_out_q;
  assign out_valid  = out_valid_q;
  assign loop_len   = len_q;
  assign loop_valid = valid_q;
  assign state      = state_q;

endmodule

// File: tb/tb_loop_recorder.sv
// Directed bench for loop_recorder: a reference model predicts every output sample into queues,
// two DUTs (monitor off and on) are compared as their out_valid strobes arrive.
module tb_loop_recorder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_tick = 1'b0;
  logic [DATA_W-1:0] sig_in = '0;
  logic              rec = 1'b0;
  logic              play = 1'b0;
  logic              overdub = 1'b0;
  logic              clear = 1'b0;

  logic [DATA_W-1:0] a_sig_out, b_sig_out;
  logic              a_out_valid, b_out_valid;
  logic [ADDR_W:0]   a_loop_len, b_loop_len;
  logic              a_loop_valid, b_loop_valid;
  logic [1:0]        a_state, b_state;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_mon_q[$];

  // reference model state
  int                m_state;
  int                m_ptr;
  int                m_len;
  logic              m_valid;
  logic [DATA_W-1:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  loop_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MONITOR(0)) u_dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .sig_in(sig_in),
    .rec(rec), .play(play), .overdub(overdub), .clear(clear),
    .sig_out(a_sig_out), .out_valid(a_out_valid), .loop_len(a_loop_len),
    .loop_valid(a_loop_valid), .state(a_state)
  );

  loop_recorder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MONITOR(1)) u_mon (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .sig_in(sig_in),
    .rec(rec), .play(play), .overdub(overdub), .clear(clear),
    .sig_out(b_sig_out), .out_valid(b_out_valid), .loop_len(b_loop_len),
    .loop_valid(b_loop_valid), .state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] sat16(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // Scoreboard: pop one expected sample per out_valid strobe of each DUT.
  always @(negedge clk) begin
    if (a_out_valid) begin
      check("a_out_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("a_sig_out", 32'(a_sig_out), 32'(exp_q.pop_front()));
    end
    if (b_out_valid) begin
      check("b_out_expected", 32'(exp_mon_q.size() > 0), 32'd1);
      if (exp_mon_q.size() > 0) check("b_sig_out", 32'(b_sig_out), 32'(exp_mon_q.pop_front()));
    end
  end

  task automatic model_reset();
    m_state = 0;
    m_ptr   = 0;
    m_len   = 0;
    m_valid = 1'b0;
  endtask

  task automatic model_tick(input logic r, input logic p, input logic o, input logic [DATA_W-1:0] din);
    logic [DATA_W-1:0] q;
    case (m_state)
      0: begin
        exp_q.push_back('0);
        exp_mon_q.push_back('0);
        if (r) begin
          m_state = 1; m_ptr = 0; m_len = 0; m_valid = 1'b0;
        end else if (p && m_valid) begin
          m_state = 2; m_ptr = 0;
        end
      end
      1: begin
        exp_q.push_back(din);
        exp_mon_q.push_back(din);
        if (r) begin
          m_mem[m_ptr] = din;
          if (m_ptr == DEPTH - 1) begin
            m_len = DEPTH; m_valid = 1'b1; m_ptr = 0; m_state = 2;
          end else begin
            m_ptr++;
          end
        end else if (m_ptr > 0) begin
          m_len = m_ptr; m_valid = 1'b1; m_ptr = 0; m_state = 2;
        end else begin
          m_state = 0;
        end
      end
      default: begin
        q = m_mem[m_ptr];
        exp_q.push_back(q);
        exp_mon_q.push_back(sat16(q, din));
        if (r) begin
          m_state = 1; m_ptr = 0; m_len = 0; m_valid = 1'b0;
        end else if (!p) begin
          m_state = 0; m_ptr = 0;
        end else begin
          if (o) m_mem[m_ptr] = sat16(q, din);
          m_state = o ? 3 : 2;
          m_ptr   = (m_ptr == m_len - 1) ? 0 : m_ptr + 1;
        end
      end
    endcase
  endtask

  // Drive one sample tick (optionally with clear on the same cycle), then idle 3 clocks.
  task automatic do_tick(input logic r, input logic p, input logic o,
                         input logic [DATA_W-1:0] din, input logic clr);
    if (clr) model_reset();
    else     model_tick(r, p, o, din);
    rec = r; play = p; overdub = o; sig_in = din; clear = clr;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_state"}, 32'(a_state), 32'(m_state));
    check({tag, "_len"}, 32'(a_loop_len), 32'(m_len));
    check({tag, "_valid"}, 32'(a_loop_valid), 32'(m_valid));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_flags(tag);
    check({tag, "_sig_out"}, 32'(a_sig_out), 32'd0);
    check({tag, "_out_valid"}, 32'(a_out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    do_reset("reset");

    // rec beats play in IDLE; rec dropped before any sample returns to IDLE
    do_tick(1'b1, 1'b1, 1'b0, 16'h0055, 1'b0);
    check_flags("recplay");
    do_tick(1'b0, 1'b1, 1'b0, 16'h0066, 1'b0);
    check_flags("rec_empty");

    // five-sample take, then play wraps through it
    do_tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 1; i <= 5; i++) do_tick(1'b1, 1'b0, 1'b0, 16'(i), 1'b0);
    do_tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_flags("take5");
    for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b1, 1'b0, 16'($urandom_range(0, 16'hFFFF)), 1'b0);
    check_flags("play5");

    // single-sample loop
    do_tick(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    do_tick(1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
    do_tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_flags("take1");
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b0, 16'($urandom_range(0, 16'hFFFF)), 1'b0);

    do_reset("reset_play");

    // full-depth take auto-stops into PLAY; the next input is not stored
    do_tick(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_tick(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i), 1'b0);
    check_flags("full");
    do_tick(1'b0, 1'b1, 1'b0, 16'h0BAD, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) do_tick(1'b0, 1'b1, 1'b0, 16'($urandom_range(0, 16'hFFFF)), 1'b0);
    check_flags("full_play");

    // positive saturation through overdub
    do_tick(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b0, 16'h7000, 1'b0);
    do_tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b1, 16'h2000, 1'b0);
    check_flags("od_pos");
    do_tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    check_flags("od_exit");
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b0, 16'h0001, 1'b0);

    // negative saturation through overdub
    do_tick(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b1, 1'b1, 1'b0, 16'h9000, 1'b0);
    do_tick(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b1, 16'h9000, 1'b0);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0);
    check("neg_sat_mem", 32'(m_mem[0]), 32'h8000);

    // clear on a tick during overdub discards the loop; play then stays in IDLE
    do_tick(1'b0, 1'b1, 1'b1, 16'h0100, 1'b0);
    check_flags("od_again");
    do_tick(1'b0, 1'b1, 1'b1, 16'h0100, 1'b1);
    check_flags("clear");
    check("clear_sig_out", 32'(a_sig_out), 32'd0);
    do_tick(1'b0, 1'b1, 1'b0, 16'h0200, 1'b0);
    check_flags("play_after_clear");

    repeat (8) @(negedge clk);
    check("a_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_mon_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
